// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial adder. Captures two WIDTH-bit operands and a carry-in
//            on start, feeds one bit pair per clock (LSB first) through a
//            single 1-bit full-adder cell with the carry recirculated in a
//            flip-flop, then presents {cout,sum} with a one-cycle done pulse.
// Options  : `define SERIAL_ADDER_OVF_EN adds a registered signed-overflow
//            output (ovf).
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Combinational 1-bit full-adder cell.
// ----------------------------------------------------------------------------
module serial_adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// ----------------------------------------------------------------------------
// Sequential wrapper around the full-adder cell.
// ----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // The bit counter needs at least one bit even when WIDTH=1.
  localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;     // operand A shift register
  logic [WIDTH-1:0] sb_q, sb_d;     // operand B shift register
  logic             c_q, c_d;       // recirculated carry
  logic [CNT_W-1:0] cnt_q, cnt_d;   // bit position being added
  logic [WIDTH-1:0] r_q, r_d;       // partial result, filled from the MSB end
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] r_shift;        // R after shifting in this cycle's sum bit

  // Illegal widths are caught at elaboration rather than producing odd logic.
  generate
    if ((WIDTH < 1) || (WIDTH > 32)) begin : g_width_check
      $error("serial_adder: WIDTH must be in 1..32");
    end
  endgenerate

  serial_adder_fa u_fa (
    .a_i (sa_q[0]),
    .b_i (sb_q[0]),
    .c_i (c_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // A 1-bit result register has nothing to shift; the new bit is the result.
  generate
    if (WIDTH == 1) begin : g_r_w1
      assign r_shift = fa_s;
    end else begin : g_r_wn
      assign r_shift = {fa_s, r_q[WIDTH-1:1]};
    end
  endgenerate

  // Next-state and datapath update; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          c_d     = cin;
          cnt_d   = '0;
          r_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        r_d   = r_shift;
        c_d   = fa_c;
        cnt_d = cnt_q + 1'b1;
        // Outputs are only ever written here, so no partial result leaks out.
        if (cnt_q == LAST_CNT) begin
          sum_d   = r_shift;
          cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
          // c_q is the carry entering the MSB position on this final step.
          ovf_d   = c_q ^ fa_c;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any addition in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      r_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

  // busy and done decode distinct states and must never overlap.
  a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(busy && done));

  // The result only moves on the completing edge.
  a_sum_stable: assert property (@(posedge clk) disable iff (!rst_n)
    !((state_q == S_RUN) && (cnt_q == LAST_CNT)) |=> $stable(sum) && $stable(cout));

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances,
// table-driven vectors with a scoreboard queue, plus multi-cycle sequences.
module tb_serial_adder;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf1;
`endif

  int errors = 0;
  int checks = 0;
  exp_t sb_q[$];
  vec_t tbl[8];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse of the 8-bit instance pops one expectation.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sum8", {24'd0, sum8}, {24'd0, e.sum});
        check("cout8", {31'd0, cout8}, {31'd0, e.cout});
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf8", {31'd0, ovf8}, {31'd0, e.ovf});
`endif
      end
    end
  end

  // Start one 8-bit addition and check the busy/done timing around it.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                      input exp_t e, input string name);
    logic ok;
    ok = 1'b1;
    @(negedge clk);
    start8 = 1'b1; a8 = ta; b8 = tb_v; cin8 = tc;
    sb_q.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (!(busy8 === 1'b1 && done8 === 1'b0)) ok = 1'b0;
      @(negedge clk);
    end
    if (!(busy8 === 1'b0 && done8 === 1'b1)) ok = 1'b0;
    check($sformatf("%s_latency", name), {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t       e;
    logic [8:0] t;
    logic [7:0] ra, rb;
    logic       rc, ok, exp_busy, exp_done;
    logic [2:0] v;
    logic [1:0] ex;
    int         dones;

    tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[3] = '{8'h3C, 8'h41, 1'b0, 8'h7D, 1'b0, 1'b0};
    tbl[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    tbl[7] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};

    // Reset state
    @(negedge clk);
    #1;
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_sum", {24'd0, sum8}, 32'd0);
    check("rst_cout", {31'd0, cout8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      e.sum = tbl[i].sum; e.cout = tbl[i].cout; e.ovf = tbl[i].ovf;
      run8(tbl[i].a, tbl[i].b, tbl[i].cin, e, $sformatf("vec%0d", i));
    end

    // Random vectors against an arithmetic model
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      t = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      e.sum = t[7:0]; e.cout = t[8];
      e.ovf = (ra[7] == rb[7]) && (t[7] != ra[7]);
      run8(ra, rb, rc, e, $sformatf("rnd%0d", i));
    end

    // start held through RUN/DONE with operands changed mid-run
    ok = 1'b1; dones = 0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    e.sum = 8'h30; e.cout = 1'b0; e.ovf = 1'b0;
    sb_q.push_back(e);
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (j == 0) begin a8 = 8'hFF; b8 = 8'hFF; end
      if (j == 9) begin
        e.sum = 8'hFE; e.cout = 1'b1; e.ovf = 1'b0;
        sb_q.push_back(e);
      end
      if (j == 10) start8 = 1'b0;
      exp_busy = (j < 8) || (j >= 10 && j < 18);
      exp_done = (j == 8) || (j == 18);
      if (busy8 !== exp_busy || done8 !== exp_done) ok = 1'b0;
      if (done8 === 1'b1) dones++;
    end
    check("hold_start_pattern", {31'd0, ok}, 32'd1);
    check("hold_start_dones", dones, 2);

    // Reset in the fourth RUN cycle
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h55; b8 = 8'h22; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy8}, 32'd0);
    check("midrst_done", {31'd0, done8}, 32'd0);
    check("midrst_sum", {24'd0, sum8}, 32'd0);
    check("midrst_cout", {31'd0, cout8}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (busy8 !== 1'b0 || done8 !== 1'b0) ok = 1'b0;
    end
    check("midrst_idle", {31'd0, ok}, 32'd1);
    e.sum = 8'h7D; e.cout = 1'b0; e.ovf = 1'b0;
    run8(8'h3C, 8'h41, 1'b0, e, "post_rst");

    // WIDTH=1 full-adder truth table
    for (int k = 0; k < 8; k++) begin
      v  = 3'(k);
      ex = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      @(negedge clk);
      start1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0];
      @(negedge clk);
      start1 = 1'b0;
      check($sformatf("w1_busy%0d", k), {30'd0, busy1, done1}, 32'd2);
      @(negedge clk);
      check($sformatf("w1_done%0d", k), {30'd0, busy1, done1}, 32'd1);
      check($sformatf("w1_res%0d", k), {30'd0, cout1, sum1}, {30'd0, ex});
    end

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder stage wrapped around a single 1-bit full-adder cell.
- Accepts two WIDTH-bit operands and a carry-in on a start request.
- Feeds the full-adder cell one bit pair per clock, LSB first, and recirculates the carry through a flip-flop.
- Presents the WIDTH-bit sum and carry-out with a one-cycle done pulse.
- Sits between an operand source (register file or testbench driver) and any result consumer. It is the sequential wrapper for the team's combinational full adder.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only in IDLE.
a  input  WIDTH  operand A, captured when start is accepted.
b  input  WIDTH  operand B, captured when start is accepted.
cin  input  1  carry-in, captured when start is accepted.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse, high while in DONE.
sum  output  WIDTH  registered result; held until next completion.
cout  output  1  registered carry-out; held until next completion.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State=IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry FF and bit counter cleared.
  - Reset mid-operation aborts the addition; no done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge N captures a into shift register SA, b into SB, cin into carry FF C.
  - Counter cleared to 0; state -> RUN.
  - start=0: remain IDLE.
- RUN (edges N+1 .. N+WIDTH):
  - Each edge computes s = SA[0]^SB[0]^C and c = majority(SA[0],SB[0],C) through the full-adder cell.
  - Shifts SA and SB right by 1, fill 0.
  - Shifts s into the MSB of the internal result register R (right shift).
  - C <= c; counter increments.
  - On the edge where counter reaches WIDTH-1 (edge N+WIDTH), sum <= final R and cout <= c; state -> DONE.
- DONE:
  - done=1, busy=0 for exactly one cycle.
  - Next edge -> IDLE unconditionally.
- Latency:
  - start sampled at edge N; busy high in cycles after edges N..N+WIDTH-1.
  - done high in the cycle after edge N+WIDTH.
  - Next start accepted at edge N+WIDTH+2 at the earliest.
- start in RUN or DONE is ignored, not queued; a, b and cin changes during RUN have no effect.
- sum/cout never show partial results; they change only at the completing edge.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no other width extension.
- WIDTH=1: RUN lasts one edge; the block reduces to a registered full adder with 2-cycle done latency.
- busy and done are never high simultaneously.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset to 0.
  - Signed two's-complement overflow is the carry into the MSB position XOR cout.
  - Registered at the completing edge alongside sum; held until next completion.
- Undefined:
  - Port ovf is absent and no extra logic is generated.
  - All other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x00, b=0x00, cin=0, start pulsed at edge 0:
  - sum=0x00, cout=0.
  - busy high for 8 cycles; done high only in the cycle after edge 8.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. Then a=0x3C, b=0x41, cin=0 -> sum=0x7D, cout=0.
- WIDTH=1, all 8 combinations of a, b, cin -> {cout,sum} matches the full-adder truth table (e.g. 1,1,1 -> sum=1, cout=1); done 2 cycles after each start.
- Busy rejection: start held high through RUN with a and b changed mid-run -> exactly one done; result reflects the originally captured operands; a new start is accepted only after returning to IDLE.
- Reset mid-operation: rst_n=0 at cycle 4 of RUN -> outputs 0 immediately, no done pulse, IDLE after release; the next start completes normally.
- SERIAL_ADDER_OVF_EN defined, WIDTH=8:
  - a=0x7F, b=0x01 -> sum=0x80, ovf=1, cout=0.
  - a=0xFF, b=0x01 -> sum=0x00, ovf=0, cout=1.
